// File: rtl/mcp_pkg.sv
// Shared definitions for the matrix coprocessor blocks.
//   ELEM_W / DIM_MAX / VEC_W : element width, max dimension, operand vector width
//   size_e                   : dimension codes carried on the size input
//   state_e                  : load sequencer states
//   elem_msb(r,c)            : MSB of element (r,c) inside an operand vector
package mcp_pkg;

    localparam int ELEM_W  = 8;
    localparam int DIM_MAX = 5;
    localparam int VEC_W   = DIM_MAX * DIM_MAX * ELEM_W;

    typedef enum logic [1:0] {
        SZ_2X2 = 2'b00,
        SZ_3X3 = 2'b01,
        SZ_4X4 = 2'b10,
        SZ_5X5 = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Row-major with a fixed stride of DIM_MAX, element (0,0) at the top.
    function automatic int elem_msb(input int r, input int c);
        return VEC_W - 1 - ELEM_W * (DIM_MAX * r + c);
    endfunction

endpackage

// File: rtl/mat_pos_counter.sv
// Row/column walker over an n x n window, row-major.
//   clk, rst_n : clock, async active-low reset
//   n          : active dimension (2..5)
//   inc        : advance one position
//   clear      : return to (0,0); wins over inc
//   row, col   : current position
//   last       : current position is (n-1, n-1)
module mat_pos_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] n,
    input  logic       inc,
    input  logic       clear,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       last
);

    logic [2:0] n_m1;

    assign n_m1 = n - 3'd1;
    assign last = (row == n_m1) && (col == n_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (last) begin
                row <= '0;
                col <= '0;
            end else if (col == n_m1) begin
                col <= '0;
                row <= row + 3'd1;
            end else begin
                col <= col + 3'd1;
            end
        end
    end

endmodule

// File: rtl/matrix_load_ctrl.sv
// Streams matrix elements from the host bus into two organised operand
// vectors (5x5 grid of elements, row-major, zero outside the n x n window).
//   clk, rst_n         : clock, async active-low reset
//   start, size        : begin a load (honoured in IDLE only), size code
//   in_valid, in_data  : element stream, matrix 1 then matrix 2
//   in_ready           : element accepted when in_valid && in_ready
//   matrix1/2_out      : registered operand vectors
//   busy, done         : loading / one-cycle completion pulse
//   mat_valid          : operands complete, held until the next start
module matrix_load_ctrl
    import mcp_pkg::*;
#(
    parameter int ELEM_W  = mcp_pkg::ELEM_W,
    parameter int DIM_MAX = mcp_pkg::DIM_MAX
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [1:0]                        size,
    input  logic                              in_valid,
    input  logic [ELEM_W-1:0]                 in_data,
    output logic                              in_ready,
    output logic [DIM_MAX*DIM_MAX*ELEM_W-1:0] matrix1_out,
    output logic [DIM_MAX*DIM_MAX*ELEM_W-1:0] matrix2_out,
    output logic                              busy,
    output logic                              done,
    output logic                              mat_valid
);

    localparam int NPOS = DIM_MAX * DIM_MAX;

    state_e     state_q, state_d;
    logic [2:0] n_q;
    logic [2:0] row, col;
    logic       last;
    logic       accept;
    logic       start_ok;
    logic [4:0] wr_idx;

    // Index 0 is the most significant slot, so the packed arrays map
    // straight onto the required operand layout.
    logic [0:NPOS-1][ELEM_W-1:0] m1_q, m2_q;

    assign accept   = in_valid && in_ready;
    assign start_ok = (state_q == IDLE) && start;
    assign wr_idx   = 5'(row) * 5'(DIM_MAX) + 5'(col);

    mat_pos_counter u_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .n     (n_q),
        .inc   (accept),
        .clear (start_ok),
        .row   (row),
        .col   (col),
        .last  (last)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD_A;
            LOAD_A:  if (accept && last) state_d = LOAD_B;
            LOAD_B:  if (accept && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            LOAD_A, LOAD_B: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand storage, latched size and completion flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q       <= 3'd2;
            m1_q      <= '0;
            m2_q      <= '0;
            mat_valid <= 1'b0;
        end else if (start_ok) begin
            n_q       <= {1'b0, size} + 3'd2;
            m1_q      <= '0;
            m2_q      <= '0;
            mat_valid <= 1'b0;
        end else if (accept) begin
            if (state_q == LOAD_A) begin
                m1_q[wr_idx] <= in_data;
            end else begin
                m2_q[wr_idx] <= in_data;
                // Flag rises together with the move into DONE.
                if (last) mat_valid <= 1'b1;
            end
        end
    end

    assign matrix1_out = m1_q;
    assign matrix2_out = m2_q;

endmodule

// File: tb/tb_matrix_load_ctrl.sv
module tb_matrix_load_ctrl;
    import mcp_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       size = 2'b00;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_ready, busy, done, mat_valid;
    logic [VEC_W-1:0] matrix1_out, matrix2_out;

    typedef struct {
        logic [VEC_W-1:0] m1;
        logic [VEC_W-1:0] m2;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] data_a[25];
    logic [7:0] data_b[25];

    matrix_load_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .size        (size),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .matrix1_out (matrix1_out),
        .matrix2_out (matrix2_out),
        .busy        (busy),
        .done        (done),
        .mat_valid   (mat_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full load. pat: 0 = in_valid always high, 1 = high on odd cycles.
    // hook_cyc: cycle (relative to start) at which a stray start and size=11
    // are driven. hook_done: drive a start during the DONE cycle.
    task automatic run_load(input int sz, input int pat, input int hook_cyc,
                            input bit hook_done, output int beats);
        int   n, nn, cyc, beat;
        bit   acc;
        exp_t e;
        logic [0:24][7:0] t1, t2;
        n  = sz + 2;
        nn = n * n;
        t1 = '0;
        t2 = '0;
        for (int k = 0; k < nn; k++) begin
            t1[5'(5 * (k / n) + k % n)] = data_a[5'(k)];
            t2[5'(5 * (k / n) + k % n)] = data_b[5'(k)];
        end
        e.m1 = t1;
        e.m2 = t2;
        sb.push_back(e);

        start = 1'b1;
        size  = 2'(sz);
        tick();
        start = 1'b0;
        cyc   = 1;
        beat  = 0;

        n_checks++;
        if (matrix1_out !== '0 || matrix2_out !== '0 || mat_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_clear: m1=%h m2=%h mat_valid=%b busy=%b, want zeros/0/1",
                     matrix1_out, matrix2_out, mat_valid, busy);
        end

        while (done !== 1'b1 && cyc < 400) begin
            in_valid = (pat == 0) ? 1'b1 : (cyc % 2 == 1);
            if (beat < nn)          in_data = data_a[5'(beat)];
            else if (beat < 2 * nn) in_data = data_b[5'(beat - nn)];
            else                    in_data = 8'hEE;
            start = (cyc == hook_cyc);
            if (cyc == hook_cyc) size = 2'b11;
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) beat++;
        end
        in_valid = 1'b0;
        start    = 1'b0;

        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_seen: done=%b after %0d cycles, want 1", done, cyc);
        end
        n_checks++;
        if (beat != 2 * nn) begin
            n_fail++;
            $display("FAIL beat_count: got %0d accepts, want %0d", beat, 2 * nn);
        end
        if (pat == 0) begin
            n_checks++;
            if (cyc != 2 * nn + 1) begin
                n_fail++;
                $display("FAIL done_latency: done at cycle %0d, want %0d", cyc, 2 * nn + 1);
            end
        end
        n_checks++;
        if (mat_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL done_flags: mat_valid=%b in_ready=%b, want 1/0", mat_valid, in_ready);
        end

        if (hook_done) begin
            start = 1'b1;
            size  = 2'b00;
        end
        tick();
        start = 1'b0;

        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || mat_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_done: done=%b busy=%b in_ready=%b mat_valid=%b, want 0/0/0/1",
                     done, busy, in_ready, mat_valid);
        end

        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: queue empty, want one entry");
        end else begin
            e = sb.pop_front();
            if (matrix1_out !== e.m1 || matrix2_out !== e.m2) begin
                n_fail++;
                $display("FAIL operands: m1=%h m2=%h, want m1=%h m2=%h",
                         matrix1_out, matrix2_out, e.m1, e.m2);
            end
        end
        beats = beat;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (matrix1_out !== '0 || matrix2_out !== '0 || in_ready !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || mat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: m1=%h m2=%h rdy=%b busy=%b done=%b mv=%b, want all 0",
                     matrix1_out, matrix2_out, in_ready, busy, done, mat_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b in_ready=%b, want 0/0", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid_load();
        start = 1'b1;
        size  = 2'b00;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_data = 8'(k + 1);
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (matrix2_out[199:184] !== 16'h0506 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: m2[199:184]=%h busy=%b, want 0506/1", matrix2_out[199:184], busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (matrix1_out !== '0 || matrix2_out !== '0 || in_ready !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || mat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_load: m1=%h m2=%h rdy=%b busy=%b done=%b mv=%b, want all 0",
                     matrix1_out, matrix2_out, in_ready, busy, done, mat_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_mid_reset: busy=%b done=%b mv=%b, want 0/0/0", busy, done, mat_valid);
        end
    endtask

    task automatic test_2x2();
        int beats;
        for (int k = 0; k < 25; k++) begin
            data_a[k] = 8'(k + 1);
            data_b[k] = 8'(k + 5);
        end
        run_load(0, 0, 0, 1'b0, beats);
        n_checks++;
        if (matrix1_out[199:184] !== 16'h0102 || matrix1_out[159:144] !== 16'h0304) begin
            n_fail++;
            $display("FAIL 2x2_layout: [199:184]=%h [159:144]=%h, want 0102/0304",
                     matrix1_out[199:184], matrix1_out[159:144]);
        end
    endtask

    task automatic test_5x5();
        int beats;
        for (int k = 0; k < 25; k++) begin
            data_a[k] = 8'(k + 1);
            data_b[k] = 8'(8'h81 + k);
        end
        run_load(3, 0, 0, 1'b0, beats);
        n_checks++;
        if (matrix1_out[7:0] !== 8'h19 || matrix2_out[199:192] !== 8'h81) begin
            n_fail++;
            $display("FAIL 5x5_corners: m1[7:0]=%h m2[199:192]=%h, want 19/81",
                     matrix1_out[7:0], matrix2_out[199:192]);
        end
    endtask

    task automatic test_3x3_stall();
        int beats;
        for (int k = 0; k < 25; k++) begin
            data_a[k] = 8'(k + 1);
            data_b[k] = 8'(8'h40 + k);
        end
        run_load(1, 1, 0, 1'b0, beats);
        n_checks++;
        if (matrix1_out[elem_msb(1, 0) -: 8] !== 8'h04) begin
            n_fail++;
            $display("FAIL 3x3_idx5: got %h, want 04", matrix1_out[elem_msb(1, 0) -: 8]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || mat_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL 3x3_hold: done=%b mat_valid=%b, want 0/1", done, mat_valid);
            end
        end
    endtask

    task automatic test_4x4_ignored_start();
        int beats;
        logic [VEC_W-1:0] mask;
        for (int k = 0; k < 25; k++) begin
            data_a[k] = 8'(8'h10 + k);
            data_b[k] = 8'(8'h30 + k);
        end
        run_load(2, 0, 5, 1'b1, beats);
        mask = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (r == 4 || c == 4) mask[elem_msb(r, c) -: 8] = 8'hFF;
        n_checks++;
        if ((matrix1_out & mask) !== '0 || (matrix2_out & mask) !== '0) begin
            n_fail++;
            $display("FAIL 4x4_edge_zero: m1=%h m2=%h, want row4/col4 zero", matrix1_out, matrix2_out);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || mat_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL 4x4_still_idle: busy=%b mat_valid=%b, want 0/1", busy, mat_valid);
        end
    endtask

    task automatic test_back_to_back();
        int beats;
        for (int k = 0; k < 25; k++) begin
            data_a[k] = 8'hFF;
            data_b[k] = 8'hFF;
        end
        run_load(3, 0, 0, 1'b0, beats);
        for (int k = 0; k < 25; k++) begin
            data_a[k] = 8'(k + 1);
            data_b[k] = 8'(k + 5);
        end
        run_load(0, 0, 0, 1'b0, beats);
        n_checks++;
        if (matrix1_out[183:160] !== '0 || matrix1_out[143:0] !== '0 || matrix2_out[143:0] !== '0) begin
            n_fail++;
            $display("FAIL b2b_stale: m1=%h m2=%h, want zero outside 2x2", matrix1_out, matrix2_out);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_load();
        test_2x2();
        test_5x5();
        test_3x3_stall();
        test_4x4_ignored_start();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
